imem_sram_responder: RTL and testbench

IMEM_SRAM_RESPONDER -- requirements
Module: imem_sram_responder

---
 rtl/imem_sram_responder.sv | 139 +++++++++++++
 tb/tb_imem_sram_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_sram_responder.sv
// Instruction fetch responder: serves 32-bit words from a 16-bit SRAM via two
// half-word reads, with a one-entry line buffer for repeated fetches.
module imem_sram_responder #(
    parameter int unsigned SRAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic        busy,
    output logic [17:0] sram_addr,
    output logic        sram_rd,
    input  logic [15:0] sram_rdata
);

    localparam logic [3:0] WAIT_LAST = 4'(SRAM_WAIT - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [29:0] tag;
    logic [15:0] low_half;
    logic        buf_valid;
    logic [29:0] buf_tag;
    logic [31:0] buf_data;
    logic        hit;
    logic        accept;
    logic        wait_done;
    logic        unused_addr_bits;

    assign hit              = buf_valid && (buf_tag == req_addr[31:2]);
    assign accept           = ((state == IDLE) || (state == DONE)) && req_valid && !flush;
    assign wait_done        = (wait_cnt == WAIT_LAST);
    assign unused_addr_bits = ^req_addr[1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush aborts in-flight reads and drops new requests
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = hit ? DONE : LOW;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOW: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (wait_done) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (wait_done) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and handshake outputs
    always_comb begin
        sram_rd    = 1'b0;
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (state)
            LOW, HIGH: begin
                sram_rd = 1'b1;
                busy    = 1'b1;
            end
            IDLE: begin
                busy = req_valid && !flush && !hit;
            end
            DONE: begin
                busy       = req_valid && !flush && !hit;
                resp_valid = !flush;
            end
            default: ;
        endcase
    end

    // Datapath: wait counter, SRAM address, half-word capture and line buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            tag       <= 30'd0;
            low_half  <= 16'd0;
            sram_addr <= 18'd0;
            resp_inst <= 32'd0;
            buf_valid <= 1'b0;
            buf_tag   <= 30'd0;
            buf_data  <= 32'd0;
        end else if (accept) begin
            wait_cnt <= 4'd0;
            if (hit) begin
                resp_inst <= buf_data;
            end else begin
                tag       <= req_addr[31:2];
                sram_addr <= {req_addr[18:2], 1'b0};
            end
        end else if ((state == LOW) || (state == HIGH)) begin
            if (flush || wait_done) begin
                wait_cnt <= 4'd0;
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (!flush && wait_done) begin
                if (state == LOW) begin
                    low_half  <= sram_rdata;
                    sram_addr <= {tag[16:0], 1'b1};
                end else begin
                    resp_inst <= {sram_rdata, low_half};
                    buf_valid <= 1'b1;
                    buf_tag   <= tag;
                    buf_data  <= {sram_rdata, low_half};
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_sram_responder.sv
// Directed bench for imem_sram_responder: one instance with SRAM_WAIT=1 and
// one with SRAM_WAIT=3, both reading from a shared half-word SRAM model.
module tb_imem_sram_responder;

    logic        clk;
    logic        rst;
    logic        flush;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        busy;
    logic [17:0] sram_addr;
    logic        sram_rd;
    logic [15:0] sram_rdata;

    logic        req_valid3;
    logic [31:0] req_addr3;
    logic        resp_valid3;
    logic [31:0] resp_inst3;
    logic        busy3;
    logic [17:0] sram_addr3;
    logic        sram_rd3;
    logic [15:0] sram_rdata3;

    logic [15:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    assign sram_rdata  = (sram_addr  < 18'd128) ? mem[sram_addr[6:0]]  : 16'hDEAD;
    assign sram_rdata3 = (sram_addr3 < 18'd128) ? mem[sram_addr3[6:0]] : 16'hDEAD;

    imem_sram_responder #(.SRAM_WAIT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .flush(flush), .resp_valid(resp_valid), .resp_inst(resp_inst),
        .busy(busy), .sram_addr(sram_addr), .sram_rd(sram_rd),
        .sram_rdata(sram_rdata)
    );

    imem_sram_responder #(.SRAM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_addr(req_addr3),
        .flush(1'b0), .resp_valid(resp_valid3), .resp_inst(resp_inst3),
        .busy(busy3), .sram_addr(sram_addr3), .sram_rd(sram_rd3),
        .sram_rdata(sram_rdata3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        req_valid = 1'b0; req_addr = 32'd0;
        req_valid3 = 1'b0; req_addr3 = 32'd0;
        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 3);
        mem[0] = 16'h0014; mem[1] = 16'hE3A0;
        mem[2] = 16'h1234; mem[3] = 16'hABCD;
        mem[4] = 16'h5678; mem[5] = 16'h9ABC;
        mem[8'h48] = 16'h0F0F; mem[8'h49] = 16'h5A5A;
        #3;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b, expected 0", resp_valid); end
        checks++; if (resp_inst !== 32'd0) begin errors++; $display("FAIL rst_resp_inst: got %h, expected 0", resp_inst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        checks++; if (sram_rd !== 1'b0) begin errors++; $display("FAIL rst_sram_rd: got %b, expected 0", sram_rd); end
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL rst_sram_addr: got %h, expected 0", sram_addr); end
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_miss();
        step(); req_valid = 1'b1; req_addr = 32'h0; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL miss_busy_c0: got %b, expected 1", busy); end
        step(); req_valid = 1'b0; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL miss_busy_c1: got %b, expected 1", busy); end
        checks++; if (sram_rd !== 1'b1) begin errors++; $display("FAIL miss_rd_c1: got %b, expected 1", sram_rd); end
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL miss_addr_c1: got %h, expected 0", sram_addr); end
        step(); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL miss_busy_c2: got %b, expected 1", busy); end
        checks++; if (sram_addr !== 18'd1) begin errors++; $display("FAIL miss_addr_c2: got %h, expected 1", sram_addr); end
        step(); #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL miss_resp_valid: got %b, expected 1", resp_valid); end
        checks++; if (resp_inst !== 32'hE3A00014) begin errors++; $display("FAIL miss_resp_inst: got %h, expected e3a00014", resp_inst); end
        checks++; if (sram_rd !== 1'b0) begin errors++; $display("FAIL miss_rd_done: got %b, expected 0", sram_rd); end
    endtask

    task automatic test_hit();
        step(); req_valid = 1'b1; req_addr = 32'h0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hit_busy: got %b, expected 0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL hit_idle_resp: got %b, expected 0", resp_valid); end
        step(); req_valid = 1'b0; #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hit_resp_valid: got %b, expected 1", resp_valid); end
        checks++; if (resp_inst !== 32'hE3A00014) begin errors++; $display("FAIL hit_resp_inst: got %h, expected e3a00014", resp_inst); end
        checks++; if (sram_rd !== 1'b0) begin errors++; $display("FAIL hit_no_rd: got %b, expected 0", sram_rd); end
    endtask

    // Entered in the DONE cycle left by test_hit
    task automatic test_back_to_back();
        req_valid = 1'b1; req_addr = 32'h4; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b, expected 1", busy); end
        step(); req_valid = 1'b0; #1;
        checks++; if (sram_addr !== 18'd2) begin errors++; $display("FAIL b2b_addr_low: got %h, expected 2", sram_addr); end
        step(); #1;
        checks++; if (sram_addr !== 18'd3) begin errors++; $display("FAIL b2b_addr_high: got %h, expected 3", sram_addr); end
        step(); #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_resp_valid: got %b, expected 1", resp_valid); end
        checks++; if (resp_inst !== 32'hABCD1234) begin errors++; $display("FAIL b2b_resp_inst: got %h, expected abcd1234", resp_inst); end
        step(); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %b, expected 0", resp_valid); end
        checks++; if (resp_inst !== 32'hABCD1234) begin errors++; $display("FAIL b2b_hold_inst: got %h, expected abcd1234", resp_inst); end
        checks++; if (sram_addr !== 18'd3) begin errors++; $display("FAIL b2b_hold_addr: got %h, expected 3", sram_addr); end
    endtask

    task automatic test_flush();
        step(); req_valid = 1'b1; req_addr = 32'h90; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b, expected 1", busy); end
        step(); req_valid = 1'b0; #1;
        checks++; if (sram_addr !== 18'h48) begin errors++; $display("FAIL flush_addr_low: got %h, expected 48", sram_addr); end
        step(); flush = 1'b1; #1;
        checks++; if (sram_addr !== 18'h49) begin errors++; $display("FAIL flush_addr_high: got %h, expected 49", sram_addr); end
        step(); flush = 1'b0; #1;
        checks++; if (sram_rd !== 1'b0) begin errors++; $display("FAIL flush_idle_rd: got %b, expected 0", sram_rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b, expected 0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_no_resp0: got %b, expected 0", resp_valid); end
        step(); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_no_resp1: got %b, expected 0", resp_valid); end
        step(); req_valid = 1'b1; req_addr = 32'h90; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_remiss: got %b, expected 1", busy); end
        step(); req_valid = 1'b0;
        step(); step(); #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL flush_refetch_valid: got %b, expected 1", resp_valid); end
        checks++; if (resp_inst !== 32'h5A5A0F0F) begin errors++; $display("FAIL flush_refetch_inst: got %h, expected 5a5a0f0f", resp_inst); end
        // Flush beats a buffered hit in the same cycle
        step(); req_valid = 1'b1; req_addr = 32'h90; flush = 1'b1; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b, expected 0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL prio_resp_now: got %b, expected 0", resp_valid); end
        step(); req_valid = 1'b0; flush = 1'b0; #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL prio_dropped: got %b, expected 0", resp_valid); end
    endtask

    task automatic test_wait_states();
        step(); req_valid3 = 1'b1; req_addr3 = 32'h8; #1;
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL ws_busy: got %b, expected 1", busy3); end
        for (int i = 1; i <= 6; i++) begin
            step(); req_valid3 = 1'b0; #1;
            checks++;
            if (sram_addr3 !== ((i <= 3) ? 18'd4 : 18'd5) || sram_rd3 !== 1'b1 || resp_valid3 !== 1'b0) begin
                errors++;
                $display("FAIL ws_cycle%0d: got addr %h rd %b valid %b, expected addr %0d rd 1 valid 0",
                         i, sram_addr3, sram_rd3, resp_valid3, (i <= 3) ? 4 : 5);
            end
        end
        step(); #1;
        checks++; if (resp_valid3 !== 1'b1) begin errors++; $display("FAIL ws_resp_valid: got %b, expected 1", resp_valid3); end
        checks++; if (resp_inst3 !== 32'h9ABC5678) begin errors++; $display("FAIL ws_resp_inst: got %h, expected 9abc5678", resp_inst3); end
    endtask

    task automatic test_reset_mid_miss();
        step(); req_valid = 1'b1; req_addr = 32'h8;
        step(); req_valid = 1'b0; #1;
        checks++; if (sram_rd !== 1'b1) begin errors++; $display("FAIL rmm_in_low: got %b, expected 1", sram_rd); end
        rst = 1'b1; #1;
        checks++; if (sram_rd !== 1'b0) begin errors++; $display("FAIL rmm_rd: got %b, expected 0", sram_rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmm_busy: got %b, expected 0", busy); end
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL rmm_addr: got %h, expected 0", sram_addr); end
        checks++; if (resp_inst !== 32'd0) begin errors++; $display("FAIL rmm_inst: got %h, expected 0", resp_inst); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rmm_valid: got %b, expected 0", resp_valid); end
        step(); rst = 1'b0;
        step(); req_valid = 1'b1; req_addr = 32'h90; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmm_post_miss: got %b, expected 1", busy); end
        step(); req_valid = 1'b0;
        step(); step(); #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rmm_post_valid: got %b, expected 1", resp_valid); end
        checks++; if (resp_inst !== 32'h5A5A0F0F) begin errors++; $display("FAIL rmm_post_inst: got %h, expected 5a5a0f0f", resp_inst); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_back_to_back();
        test_flush();
        test_wait_states();
        test_reset_mid_miss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
